// File: rtl/phase_sequencer.sv
// phase_sequencer: microcode phase/state sequencer (FETCH/EXEC/ENTRY/WAIT/HALT).
// Optional macro PHASE_SEQ_IRQ_SYNC_EN adds a two-flop irq synchroniser.
`default_nettype none

module phase_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uc_end,
  input  logic       uc_stall,
  input  logic       halt,
  input  logic       wait_req,
  input  logic       ei,
  input  logic       di,
  input  logic       exc_req,
  input  logic       irq,
  output logic [2:0] phase,
  output logic       fetch,
  output logic       exc_triggered,
  output logic       exc_cause,
  output logic       irq_ack,
  output logic       int_enabled,
  output logic       halted,
  output logic       waiting,
  output logic       phase_err
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_ENTRY = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic       cause_q, cause_d;
  logic       ack_q, ack_d;
  logic       int_en_q, int_en_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       fetch_q, entry_q, halted_q, waiting_q;
  logic       irq_w;

`ifdef PHASE_SEQ_IRQ_SYNC_EN
  logic irq_meta_q, irq_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_q <= 1'b0;
      irq_sync_q <= 1'b0;
    end else begin
      irq_meta_q <= irq;
      irq_sync_q <= irq_meta_q;
    end
  end
  assign irq_w = irq_sync_q;
`else
  assign irq_w = irq;
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cause_d  = cause_q;
    ack_d    = 1'b0;
    int_en_d = int_en_q;
    pend_d   = pend_q;
    err_d    = err_q;
    if (!uc_stall) begin
      if (state_q == S_FETCH || state_q == S_EXEC || state_q == S_ENTRY) begin
        if (state_q == S_EXEC && exc_req) pend_d = 1'b1;
        if (uc_end) begin
          phase_d = 3'd0;
          if (state_q == S_FETCH) begin
            state_d = S_EXEC;
          end else if (state_q == S_EXEC) begin
            if (ei && !di)      int_en_d = 1'b1;
            else if (di && !ei) int_en_d = 1'b0;
            // Interrupt decision uses the pre-update enable: one-instruction shadow.
            if (pend_d) begin
              state_d = S_ENTRY;
              cause_d = 1'b1;
            end else if (halt) begin
              state_d = S_HALT;
            end else if (wait_req) begin
              state_d = S_WAIT;
            end else if (irq_w && int_en_q) begin
              state_d = S_ENTRY;
              cause_d = 1'b0;
              ack_d   = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            state_d  = S_FETCH;
            pend_d   = 1'b0;
            int_en_d = 1'b0;
          end
        end else if (phase_q == 3'd7) begin
          err_d   = 1'b1;
          state_d = S_HALT;
          phase_d = 3'd0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end else if (state_q == S_WAIT) begin
        phase_d = 3'd0;
        if (irq_w) begin
          if (int_en_q) begin
            state_d = S_ENTRY;
            cause_d = 1'b0;
            ack_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end else begin
        phase_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      phase_q   <= 3'd0;
      cause_q   <= 1'b0;
      ack_q     <= 1'b0;
      int_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      fetch_q   <= 1'b1;
      entry_q   <= 1'b0;
      halted_q  <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cause_q   <= cause_d;
      ack_q     <= ack_d;
      int_en_q  <= int_en_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      fetch_q   <= (state_d == S_FETCH);
      entry_q   <= (state_d == S_ENTRY);
      halted_q  <= (state_d == S_HALT);
      waiting_q <= (state_d == S_WAIT);
    end
  end

  assign phase         = phase_q;
  assign fetch         = fetch_q;
  assign exc_triggered = entry_q;
  assign exc_cause     = cause_q;
  assign irq_ack       = ack_q;
  assign int_enabled   = int_en_q;
  assign halted        = halted_q;
  assign waiting       = waiting_q;
  assign phase_err     = err_q;

endmodule

`default_nettype wire
